// File: rtl/tic_tac_toe_ai_player.sv
// Computer-side tic-tac-toe responder: snapshots the board, scans for a win, then a block,
// then falls back to center > corner > side, and strobes pc with the chosen cell.
module tic_tac_toe_ai_player #(
  parameter int unsigned PC_WIDTH = 1,
  parameter bit          BLOCK_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        game_over,
  input  logic [17:0] board,
  output logic [3:0]  computer_position,
  output logic        pc,
  output logic        busy,
  output logic        no_move
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN_WIN = 3'd1,
    SCAN_BLK = 3'd2,
    PREF     = 3'd3,
    ISSUE    = 3'd4,
    NOMOVE   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [17:0] r_board;
  logic [2:0]  r_line_idx;
  logic [3:0]  r_pc_cnt;
  logic [3:0]  r_pos;

  logic [11:0] w_line;
  logic [3:0]  w_cell [3];
  logic [1:0]  w_mark;
  logic [1:0]  w_val;
  logic [1:0]  w_n_mark;
  logic [1:0]  w_n_empty;
  logic [3:0]  w_hit_cell;
  logic        w_hit;
  logic [3:0]  w_pref_cell;
  logic        w_pref_ok;
  logic [3:0]  w_cand;

  function automatic logic [1:0] cell_val(input logic [17:0] b, input logic [3:0] c);
    return b[{c, 1'b0} +: 2];
  endfunction

  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Preference order: center, corners, sides.
  function automatic logic [3:0] pref_order(input int unsigned k);
    case (k)
      0:       return 4'd4;
      1:       return 4'd0;
      2:       return 4'd2;
      3:       return 4'd6;
      4:       return 4'd8;
      5:       return 4'd1;
      6:       return 4'd3;
      7:       return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

  // Line evaluation; a 11 cell matches neither the mark nor empty.
  always_comb begin
    w_line     = line_cells(r_line_idx);
    w_cell[0]  = w_line[11:8];
    w_cell[1]  = w_line[7:4];
    w_cell[2]  = w_line[3:0];
    w_mark     = (r_state == SCAN_BLK) ? 2'b01 : 2'b10;
    w_val      = '0;
    w_n_mark   = '0;
    w_n_empty  = '0;
    w_hit_cell = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_val = cell_val(r_board, w_cell[k]);
      if (w_val == w_mark) w_n_mark = w_n_mark + 2'd1;
      if (w_val == 2'b00) begin
        w_n_empty  = w_n_empty + 2'd1;
        w_hit_cell = w_cell[k];
      end
    end
    w_hit = (w_n_mark == 2'd2) && (w_n_empty == 2'd1);
  end

  always_comb begin
    w_pref_ok   = 1'b0;
    w_pref_cell = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      w_cand = pref_order(k);
      if (!w_pref_ok && cell_val(r_board, w_cand) == 2'b00) begin
        w_pref_ok   = 1'b1;
        w_pref_cell = w_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start && !game_over) w_next = SCAN_WIN;
      SCAN_WIN: begin
        if (w_hit)                   w_next = ISSUE;
        else if (r_line_idx == 3'd7) w_next = BLOCK_EN ? SCAN_BLK : PREF;
      end
      SCAN_BLK: begin
        if (w_hit)                   w_next = ISSUE;
        else if (r_line_idx == 3'd7) w_next = PREF;
      end
      PREF:     w_next = w_pref_ok ? ISSUE : NOMOVE;
      ISSUE:    if (r_pc_cnt == 4'(PC_WIDTH - 1)) w_next = IDLE;
      NOMOVE:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_board    <= '0;
      r_line_idx <= '0;
      r_pc_cnt   <= '0;
      r_pos      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !game_over) begin
            r_board    <= board;
            r_line_idx <= '0;
          end
        end
        SCAN_WIN, SCAN_BLK: begin
          if (w_hit) r_pos      <= w_hit_cell;
          else       r_line_idx <= r_line_idx + 3'd1;
        end
        PREF:    if (w_pref_ok) r_pos <= w_pref_cell;
        default: ;
      endcase
      r_pc_cnt <= (r_state == ISSUE) ? r_pc_cnt + 4'd1 : '0;
    end
  end

  // Strobes decode straight from state so reset clears them asynchronously.
  always_comb begin
    computer_position = r_pos;
    pc                = (r_state == ISSUE);
    busy              = (r_state != IDLE);
    no_move           = (r_state == NOMOVE);
  end

endmodule

// File: tb/tb_tic_tac_toe_ai_player.sv
// Scoreboard bench: stimulus pushes expected moves, a negedge monitor pops and compares.
module tb_tic_tac_toe_ai_player;

  localparam logic [1:0] E = 2'b00, P = 2'b01, C = 2'b10, X = 2'b11;

  typedef struct {
    bit mv;
    int pos;
    int cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, game_over = 1'b0;
  logic [17:0] board_a = '0, board_b = '0;
  logic [3:0]  pos_a, pos_b;
  logic        pc_a, pc_b, busy_a, busy_b, nm_a, nm_b;

  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic pcp[2] = '{1'b0, 1'b0};
  int   wcnt[2] = '{0, 0};

  tic_tac_toe_ai_player #(.PC_WIDTH(1), .BLOCK_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .game_over(game_over), .board(board_a),
    .computer_position(pos_a), .pc(pc_a), .busy(busy_a), .no_move(nm_a));

  tic_tac_toe_ai_player #(.PC_WIDTH(3), .BLOCK_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .game_over(game_over), .board(board_b),
    .computer_position(pos_b), .pc(pc_b), .busy(busy_b), .no_move(nm_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [17:0] bd(input logic [1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9);
    return {p9, p8, p7, p6, p5, p4, p3, p2, p1};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  task automatic mon(input int d, input logic p, input logic nm, input logic bz, input logic [3:0] pos);
    exp_t e;
    int   w;
    w = (d == 0) ? 1 : 3;
    if (p && !pcp[d]) begin
      if (qsize(d) == 0) begin
        n_tot++;
        $display("FAIL spurious_pc dut%0d: got pc=1 pos=%0d required no event", d, pos);
      end else begin
        e = qpop(d);
        chk($sformatf("kind_is_move dut%0d", d), 1, int'(e.mv));
        chk($sformatf("move_pos dut%0d", d), int'(pos), e.pos);
        chk($sformatf("move_edge dut%0d", d), cyc, e.cyc);
      end
      wcnt[d] = 1;
    end else if (p) begin
      wcnt[d]++;
    end
    if (!p && pcp[d]) begin
      chk($sformatf("pc_width dut%0d", d), wcnt[d], w);
      chk($sformatf("busy_after_pc dut%0d", d), int'(bz), 0);
    end
    pcp[d] = p;
    if (nm) begin
      if (qsize(d) == 0) begin
        n_tot++;
        $display("FAIL spurious_no_move dut%0d: got no_move=1 required no event", d);
      end else begin
        e = qpop(d);
        chk($sformatf("kind_is_nomove dut%0d", d), int'(e.mv), 0);
        chk($sformatf("nomove_edge dut%0d", d), cyc, e.cyc);
        chk($sformatf("nomove_pos_kept dut%0d", d), int'(pos), e.pos);
        chk($sformatf("nomove_pc dut%0d", d), int'(p), 0);
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, pc_a, nm_a, busy_a, pos_a);
    mon(1, pc_b, nm_b, busy_b, pos_b);
  end

  // Launch one request; expected event lands `lat` edges after the accepting edge.
  task automatic issue(input int d, input logic [17:0] b, input bit mv, input int pos, input int lat);
    exp_t e;
    @(negedge clock);
    if (d == 0) begin board_a = b; start_a = 1'b1; end
    else        begin board_b = b; start_b = 1'b1; end
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    e.mv  = mv;
    e.pos = pos;
    e.cyc = cyc + lat;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
    chk($sformatf("busy_on_accept dut%0d", d), int'((d == 0) ? busy_a : busy_b), 1);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!((d == 0) ? busy_a : busy_b) && qsize(d) == 0) break;
    end
    chk($sformatf("idle_in_time dut%0d", d), int'((d == 0) ? busy_a : busy_b), 0);
    chk($sformatf("queue_drained dut%0d", d), qsize(d), 0);
  endtask

  initial begin
    #2;
    chk("reset_pos", int'(pos_a), 0);
    chk("reset_pc", int'(pc_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_no_move", int'(nm_a), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Win on line {1,2,3}
    issue(0, bd(C, C, E, P, P, E, E, E, E), 1'b1, 2, 1);
    wait_idle(0);
    // Block on diagonal {1,5,9}
    issue(0, bd(P, C, E, E, P, E, E, E, E), 1'b1, 8, 15);
    wait_idle(0);
    // Empty board, game_over rising mid-scan must not abort
    issue(0, bd(E, E, E, E, E, E, E, E, E), 1'b1, 4, 17);
    game_over = 1'b1;
    wait_idle(0);
    game_over = 1'b0;
    // Win on line 2 beats a block on line 0
    issue(0, bd(P, P, E, E, E, E, C, C, E), 1'b1, 8, 3);
    wait_idle(0);
    // 11 cell must not complete line 0; real win on line 3
    issue(0, bd(C, X, E, C, E, E, E, E, E), 1'b1, 6, 4);
    wait_idle(0);
    // Preference: corner pos1
    issue(0, bd(E, E, E, E, P, E, E, E, E), 1'b1, 0, 17);
    wait_idle(0);
    // Preference: side pos2 once center/corners are taken
    issue(0, bd(P, E, C, E, X, E, C, E, P), 1'b1, 1, 17);
    wait_idle(0);
    // Full board: no_move, position kept
    issue(0, bd(C, P, C, C, P, P, P, C, C), 1'b0, 1, 17);
    wait_idle(0);

    // start while game_over is ignored
    @(negedge clock);
    board_a = bd(C, C, E, E, E, E, E, E, E);
    start_a = 1'b1;
    game_over = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    game_over = 1'b0;
    chk("start_blocked_by_game_over", int'(busy_a), 0);
    repeat (5) @(negedge clock);

    // start while busy is ignored
    issue(0, bd(P, C, E, E, P, E, E, E, E), 1'b1, 8, 15);
    repeat (3) @(negedge clock);
    board_a = bd(C, C, E, E, E, E, E, E, E);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clock);
    chk("no_queued_start", int'(busy_a), 0);

    // Asynchronous reset mid-scan
    @(negedge clock);
    board_a = bd(E, E, E, E, E, E, E, E, E);
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("midscan_reset_pos", int'(pos_a), 0);
    chk("midscan_reset_busy", int'(busy_a), 0);
    chk("midscan_reset_pc", int'(pc_a), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (25) @(negedge clock);
    chk("abandoned_scan_stays_idle", int'(busy_a), 0);

    // BLOCK_EN=0, PC_WIDTH=3 instance
    issue(1, bd(E, E, E, E, E, E, E, E, E), 1'b1, 4, 9);
    wait_idle(1);
    issue(1, bd(P, C, E, E, P, E, E, E, E), 1'b1, 2, 9);
    wait_idle(1);

    repeat (5) @(negedge clock);
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
